seq_pattern_ctrl: RTL and testbench
===================================

Name: seq_pattern_ctrl

Overview:
Programmable sequence controller that steps an 8-entry table of 3-bit codes onto output q.
- Each code is held for a programmable number of clock cycles.
- The table is replayed a programmable number of times, or forever.
- Sits between the system control logic (start/stop, table config) and the consumer of the 3-bit code stream.
- Replaces a free-running fixed-order code counter with a sequenced, configurable one.

Parameters:
- W, 3, width of each sequence code and of q.
- DEPTH, 8, number of table entries (power of two; index width log2(DEPTH)).
- PRESC_W, 8, width of step-period divider.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(DEPTH)  table write index.
- cfg_data  in  W  table write data.
- start  in  1  begin sequence (level sampled per cycle).
- stop  in  1  abort sequence.
- div  in  PRESC_W  step period minus 1; latched at start.
- loops  in  4  replay count, 0 = infinite; latched at start.
- q  out  W  current code.
- q_valid  out  1  q holds a sequence code.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (rst low, async):
  - state IDLE; q=0, q_valid=0, busy=0, done=0; index and counters 0.
  - Table loads default pattern 0,3,4,2,5,7,6,1 (entries 0..7).
- States:
  - IDLE -> RUN on start=1 and stop=0.
  - RUN -> IDLE on stop=1.
  - RUN -> DONE after the last step of the last loop.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start:
  - The edge that leaves IDLE sets idx=0, presc=div, loop_cnt=loops, q=table[0], q_valid=1, busy=1.
  - First code visible 1 cycle after start is sampled.
- Step timing:
  - In RUN, presc decrements each cycle.
  - At presc==0: reload presc=div, idx++, q=table[idx+1].
  - Each code is held exactly div+1 cycles; div=0 gives a new code every cycle.
- Wrap, when presc==0 and idx==DEPTH-1:
  - loops==0: idx=0, q=table[0], continue forever.
  - loop_cnt>1: loop_cnt--, idx=0, q=table[0].
  - loop_cnt==1: -> DONE; q=0, q_valid=0; busy=1 in DONE, done=1 for that single cycle.
  - In IDLE next cycle: busy=0, done=0.
- Stop:
  - stop in RUN wins over any step or wrap that cycle.
  - Next edge: IDLE, q=0, q_valid=0, busy=0. No done pulse.
  - stop in IDLE or DONE is ignored.
- start while busy is ignored. start & stop together in IDLE: remain IDLE.
- start held high through DONE restarts only after reaching IDLE (1 idle cycle minimum between runs).
- div and loops changes during RUN have no effect until the next start.
- Table writes:
  - Accepted in any state, written at the clock edge.
  - A write to the currently displayed entry does not alter q; it is seen on the next read of that entry.
  - A write to entry idx+1 in the same cycle as the step: q takes the old table value (read-before-write).
- rst low mid-sequence: immediate return to reset values, including the default table.

Optional Feature:
Macro SEQ_PATTERN_CTRL_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - pause=1 in RUN freezes presc, idx and loop_cnt; q and q_valid hold.
  - stop overrides pause.
  - pause is ignored in IDLE and DONE.
- Undefined: no pause port; behaviour as above.

Decomposition:
- Package seq_pattern_pkg:
  - state encoding (IDLE, RUN, DONE).
  - DEPTH and index-width constants.
  - default pattern constant array {0,3,4,2,5,7,6,1}.
- Sub-module seq_presc:
  - PRESC_W-bit down counter with load, enable (pause hook) and terminal-count output.
  - Instantiated once.

Test Plan:
- Reset, then start with div=0, loops=1 -> q=0,3,4,2,5,7,6,1 on 8 consecutive cycles with q_valid=1; then done=1 for 1 cycle with q=0, q_valid=0; then busy=0.
- div=2, loops=2 -> each code held 3 cycles; 16 codes total (48 cycles of q_valid); single done pulse.
- loops=0, div=0, stop asserted on cycle 20 after start -> q sequence wraps 1->0 twice, IDLE next edge, q=0, no done pulse.
- Write table[3]=7 and table[5]=0 while idle, start div=0 loops=1 -> q=0,3,4,7,5,0,6,1. Write table[0]=5 mid-run -> current run unaffected past entry 0.
- Assert rst low on cycle 4 of a run -> q=0, q_valid=0, busy=0 immediately; table restored to default pattern.
- With SEQ_PATTERN_CTRL_PAUSE_EN: div=0, pause high 3 cycles while q=4 -> q=4 held 4 cycles total, then 2,5,...; stop during pause -> IDLE next edge.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the sequence pattern controller.
// Holds the state encoding, table geometry and the reset-time default pattern.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int SEQ_CODE_W  = 3;
    localparam int SEQ_DEPTH   = 8;
    localparam int SEQ_IDX_W   = $clog2(SEQ_DEPTH);
    localparam int SEQ_PRESC_W = 8;

    // Entry 0 sits in the least significant slice: 0,3,4,2,5,7,6,1.
    localparam logic [SEQ_DEPTH*SEQ_CODE_W-1:0] DEFAULT_PATTERN =
        {3'd1, 3'd6, 3'd7, 3'd5, 3'd2, 3'd4, 3'd3, 3'd0};

    function automatic logic [SEQ_CODE_W-1:0] default_code(input int unsigned i);
        return DEFAULT_PATTERN[SEQ_CODE_W*(i % SEQ_DEPTH) +: SEQ_CODE_W];
    endfunction

endpackage

// File: rtl/seq_presc.sv
// Step-period down counter: load wins over enable, tc flags a zero count.
// Enable is the hook used to freeze the step timing while paused.
module seq_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [PRESC_W-1:0] load_val,
    output logic               tc
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Programmable sequence controller: steps a DEPTH-entry code table onto q.
// Optional macro SEQ_PATTERN_CTRL_PAUSE_EN adds a pause input that freezes a run.
module seq_pattern_ctrl
    import seq_pattern_pkg::*;
#(
    parameter int W       = SEQ_CODE_W,
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int PRESC_W = SEQ_PRESC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [W-1:0]             cfg_data,
    input  logic                     start,
    input  logic                     stop,
`ifdef SEQ_PATTERN_CTRL_PAUSE_EN
    input  logic                     pause,
`endif
    input  logic [PRESC_W-1:0]       div,
    input  logic [3:0]               loops,
    output logic [W-1:0]             q,
    output logic                     q_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = $clog2(DEPTH);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         loop_cnt_q, loop_cnt_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic [W-1:0]       q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [W-1:0]       table_q [DEPTH];
    logic [W-1:0]       table_d [DEPTH];

    logic               presc_load;
    logic               presc_en;
    logic [PRESC_W-1:0] presc_load_val;
    logic               presc_tc;
    logic               pause_active;
    logic [IDX_W-1:0]   idx_inc;

`ifdef SEQ_PATTERN_CTRL_PAUSE_EN
    assign pause_active = pause;
`else
    assign pause_active = 1'b0;
`endif

    assign idx_inc = idx_q + IDX_W'(1);

    seq_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk      (clk),
        .rst      (rst),
        .load     (presc_load),
        .en       (presc_en),
        .load_val (presc_load_val),
        .tc       (presc_tc)
    );

    // Reads use table_q, so a write landing on the entry being fetched is seen only next time.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        loop_cnt_d     = loop_cnt_q;
        div_d          = div_q;
        q_d            = q_q;
        q_valid_d      = q_valid_q;
        presc_load     = 1'b0;
        presc_en       = 1'b0;
        presc_load_val = div_q;

        table_d = table_q;
        if (cfg_we) begin
            table_d[cfg_addr] = cfg_data;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d        = RUN;
                    idx_d          = '0;
                    loop_cnt_d     = loops;
                    div_d          = div;
                    q_d            = table_q[0];
                    q_valid_d      = 1'b1;
                    presc_load     = 1'b1;
                    presc_load_val = div;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    loop_cnt_d = '0;
                    q_d        = '0;
                    q_valid_d  = 1'b0;
                end else if (!pause_active) begin
                    presc_en = 1'b1;
                    if (presc_tc) begin
                        presc_load = 1'b1;
                        if (idx_q == IDX_W'(DEPTH - 1)) begin
                            // loop_cnt stays 0 for an infinite run and never decrements to 0 otherwise.
                            if (loop_cnt_q == 4'd0) begin
                                idx_d = '0;
                                q_d   = table_q[0];
                            end else if (loop_cnt_q > 4'd1) begin
                                loop_cnt_d = loop_cnt_q - 4'd1;
                                idx_d      = '0;
                                q_d        = table_q[0];
                            end else begin
                                state_d    = DONE;
                                idx_d      = '0;
                                loop_cnt_d = '0;
                                q_d        = '0;
                                q_valid_d  = 1'b0;
                            end
                        end else begin
                            idx_d = idx_inc;
                            q_d   = table_q[idx_inc];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            loop_cnt_q <= '0;
            div_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            loop_cnt_q <= loop_cnt_d;
            div_q      <= div_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= W'(default_code(i));
            end
        end else begin
            table_q <= table_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Self-checking bench for seq_pattern_ctrl: vector table plus scoreboard queue.
// Pause sequences are included when SEQ_PATTERN_CTRL_PAUSE_EN is defined.
module tb_seq_pattern_ctrl;

    typedef struct {
        logic       start;
        logic       stop;
        logic       we;
        logic [2:0] addr;
        logic [2:0] data;
        logic [7:0] div;
        logic [3:0] loops;
        logic       pause;
        logic [2:0] exp_q;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    typedef struct {
        logic [2:0] q;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_data;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] div;
    logic [3:0] loops;
    logic [2:0] q;
    logic       q_valid;
    logic       busy;
    logic       done;

    int    checks;
    int    failures;
    string cur_test;
    vec_t  vecs[$];
    exp_t  sb[$];

    logic [2:0] def_pat [8] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd5, 3'd7, 3'd6, 3'd1};
    logic [2:0] mod_pat [8] = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd5, 3'd0, 3'd6, 3'd1};
    logic [2:0] wr_pat  [8] = '{3'd5, 3'd3, 3'd1, 3'd7, 3'd5, 3'd0, 3'd6, 3'd1};

    seq_pattern_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .stop     (stop),
`ifdef SEQ_PATTERN_CTRL_PAUSE_EN
        .pause    (pause),
`endif
        .div      (div),
        .loops    (loops),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic add_vec(input logic st, input logic sp, input logic we,
                           input logic [2:0] a, input logic [2:0] d,
                           input logic [7:0] dv, input logic [3:0] lp, input logic ps,
                           input logic [2:0] eq, input logic ev, input logic eb, input logic ed);
        vec_t v;
        v.start = st;   v.stop = sp;   v.we = we;     v.addr = a;
        v.data = d;     v.div = dv;    v.loops = lp;  v.pause = ps;
        v.exp_q = eq;   v.exp_valid = ev; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic add_run(input logic st, input logic sp, input logic [7:0] dv,
                           input logic [3:0] lp, input logic [2:0] eq,
                           input logic ev, input logic eb, input logic ed);
        add_vec(st, sp, 1'b0, 3'd0, 3'd0, dv, lp, 1'b0, eq, ev, eb, ed);
    endtask

    task automatic check_output(input exp_t e, input int idx);
        checks++;
        if (q !== e.q || q_valid !== e.valid || busy !== e.busy || done !== e.done) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got q=%0d q_valid=%b busy=%b done=%b, expected q=%0d q_valid=%b busy=%b done=%b",
                     cur_test, idx, q, q_valid, busy, done, e.q, e.valid, e.busy, e.done);
        end
    endtask

    // Drive each vector at the falling edge, score it 1 time unit after the rising edge.
    task automatic apply_stimulus();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start    = vecs[i].start;
            stop     = vecs[i].stop;
            cfg_we   = vecs[i].we;
            cfg_addr = vecs[i].addr;
            cfg_data = vecs[i].data;
            div      = vecs[i].div;
            loops    = vecs[i].loops;
            pause    = vecs[i].pause;
            e.q      = vecs[i].exp_q;
            e.valid  = vecs[i].exp_valid;
            e.busy   = vecs[i].exp_busy;
            e.done   = vecs[i].exp_done;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check_output(sb.pop_front(), i);
        end
        vecs.delete();
    endtask

    task automatic add_single_run(input logic [2:0] pat [8]);
        add_run(1'b1, 1'b0, 8'd0, 4'd1, pat[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            add_run(1'b0, 1'b0, 8'd0, 4'd1, pat[k], 1'b1, 1'b1, 1'b0);
        end
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t zero_e;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 3'd0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        div      = 8'd0;
        loops    = 4'd0;
        zero_e.q = 3'd0; zero_e.valid = 1'b0; zero_e.busy = 1'b0; zero_e.done = 1'b0;

        cur_test = "reset";
        #3;
        check_output(zero_e, 0);
        @(negedge clk);
        rst = 1'b1;

        cur_test = "idle_guards";
        add_run(1'b1, 1'b1, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        add_run(1'b0, 1'b1, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        cur_test = "basic_div0_loops1";
        add_single_run(def_pat);
        apply_stimulus();

        // div/loops inputs change after start and start stays high through DONE.
        cur_test = "div2_loops2";
        add_run(1'b1, 1'b0, 8'd2, 4'd2, def_pat[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 48; k++) begin
            add_run(1'b1, 1'b0, 8'd0, 4'd1, def_pat[(k / 3) % 8], 1'b1, 1'b1, 1'b0);
        end
        add_run(1'b1, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        add_run(1'b1, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        cur_test = "infinite_stop";
        add_run(1'b1, 1'b0, 8'd0, 4'd0, def_pat[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 20; k++) begin
            add_run(1'b0, 1'b0, 8'd0, 4'd0, def_pat[k % 8], 1'b1, 1'b1, 1'b0);
        end
        add_run(1'b0, 1'b1, 8'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_run(1'b0, 1'b0, 8'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        cur_test = "table_write_idle";
        add_vec(1'b0, 1'b0, 1'b1, 3'd3, 3'd7, 8'd0, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 8'd0, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_run(1'b1, 1'b0, 8'd0, 4'd1, mod_pat[0], 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 3'd0, 3'd5, 8'd0, 4'd1, 1'b0, mod_pat[1], 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 8'd0, 4'd1, 1'b0, mod_pat[2], 1'b1, 1'b1, 1'b0);
        for (int k = 3; k < 8; k++) begin
            add_run(1'b0, 1'b0, 8'd0, 4'd1, mod_pat[k], 1'b1, 1'b1, 1'b0);
        end
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        cur_test = "table_write_seen";
        add_single_run(wr_pat);
        apply_stimulus();

        cur_test = "reset_mid_run";
        add_run(1'b1, 1'b0, 8'd0, 4'd1, wr_pat[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            add_run(1'b0, 1'b0, 8'd0, 4'd1, wr_pat[k], 1'b1, 1'b1, 1'b0);
        end
        apply_stimulus();
        #2;
        rst = 1'b0;
        #1;
        check_output(zero_e, 99);
        @(negedge clk);
        rst = 1'b1;
        cur_test = "default_restored";
        add_single_run(def_pat);
        apply_stimulus();

`ifdef SEQ_PATTERN_CTRL_PAUSE_EN
        cur_test = "pause_hold";
        add_run(1'b1, 1'b0, 8'd0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b0);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            add_vec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 4'd1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
        end
        for (int k = 3; k < 8; k++) begin
            add_run(1'b0, 1'b0, 8'd0, 4'd1, def_pat[k], 1'b1, 1'b1, 1'b0);
        end
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        cur_test = "pause_stop";
        add_run(1'b1, 1'b0, 8'd0, 4'd1, 3'd0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 4'd1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        add_run(1'b0, 1'b0, 8'd0, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
